// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus initiator and its lane aligner.
package mips_bus_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mips_bus_lane_align.sv
// Combinational lane steering: store byte enables/replicated data, misalignment
// detection, and load-data extraction with sign or zero extension.
module mips_bus_lane_align
    import mips_bus_pkg::*;
(
    input  logic [1:0]               size,
    input  logic [1:0]               offset,
    input  logic                     unsigned_ld,
    input  logic [BYTE_W*LANES-1:0]  wdata,
    input  logic [BYTE_W*LANES-1:0]  rdata,
    output logic [LANES-1:0]         byteenable,
    output logic [BYTE_W*LANES-1:0]  writedata,
    output logic                     misaligned,
    output logic [BYTE_W*LANES-1:0]  rdata_ext
);

    logic [BYTE_W*LANES-1:0] shifted;

    // Lane selection and extension driven by access size
    always_comb begin
        shifted    = rdata >> {offset, 3'b000};
        byteenable = 4'b0000;
        writedata  = 32'd0;
        misaligned = 1'b0;
        rdata_ext  = 32'd0;
        case (size)
            SIZE_BYTE: begin
                byteenable = 4'b0001 << offset;
                writedata  = {4{wdata[7:0]}};
                rdata_ext  = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                misaligned = offset[0];
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{wdata[15:0]}};
                rdata_ext  = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                misaligned = (offset != 2'b00);
                byteenable = 4'b1111;
                writedata  = wdata;
                rdata_ext  = rdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_bus_initiator.sv
// Converts one sized load/store from the core into a single word-aligned bus
// transaction, with optional waitrequest timeout and registered responses.
module mips_bus_initiator
    import mips_bus_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    state_e      state;
    logic        lat_write;
    logic        lat_unsigned;
    logic [1:0]  lat_size;
    logic [1:0]  lat_offset;
    logic [31:0] wait_cnt;

    logic [1:0]  al_size;
    logic [1:0]  al_offset;
    logic        al_unsigned;
    logic [3:0]  al_be;
    logic [31:0] al_wd;
    logic        al_mis;
    logic [31:0] al_rdata;
    logic        timeout_hit;

    // Aligner sees the live request while idle, the latched request afterwards
    always_comb begin
        if (state == ST_IDLE) begin
            al_size     = req_size;
            al_offset   = req_addr[1:0];
            al_unsigned = req_unsigned;
        end else begin
            al_size     = lat_size;
            al_offset   = lat_offset;
            al_unsigned = lat_unsigned;
        end
        timeout_hit = (WAIT_LIMIT != 32'd0) && ((wait_cnt + 32'd1) == WAIT_LIMIT);
    end

    mips_bus_lane_align u_align (
        .size        (al_size),
        .offset      (al_offset),
        .unsigned_ld (al_unsigned),
        .wdata       (req_wdata),
        .rdata       (readdata),
        .byteenable  (al_be),
        .writedata   (al_wd),
        .misaligned  (al_mis),
        .rdata_ext   (al_rdata)
    );

    // Transfer FSM; every output is a register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_offset   <= 2'b00;
            wait_cnt     <= 32'd0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_error    <= 1'b0;
            address      <= 32'd0;
            read         <= 1'b0;
            write        <= 1'b0;
            byteenable   <= 4'b0000;
            writedata    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && al_mis) begin
                        state     <= ST_RESP;
                        req_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end else if (req_valid) begin
                        state        <= ST_ACCESS;
                        req_ready    <= 1'b0;
                        lat_write    <= req_write;
                        lat_unsigned <= req_unsigned;
                        lat_size     <= req_size;
                        lat_offset   <= req_addr[1:0];
                        wait_cnt     <= 32'd0;
                        address      <= {req_addr[31:2], 2'b00};
                        byteenable   <= al_be;
                        writedata    <= req_write ? al_wd : 32'd0;
                        read         <= ~req_write;
                        write        <= req_write;
                    end
                end
                ST_ACCESS: begin
                    if (!waitrequest || timeout_hit) begin
                        address    <= 32'd0;
                        read       <= 1'b0;
                        write      <= 1'b0;
                        byteenable <= 4'b0000;
                        writedata  <= 32'd0;
                        if (waitrequest || lat_write) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= waitrequest;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_DATA: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b0;
                    rsp_rdata <= al_rdata;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= 32'd0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    read      <= 1'b0;
                    write     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Randomized self-checking bench for mips_bus_initiator against an arithmetic
// model of lane steering, latency and timeout behaviour.
module tb_mips_bus_initiator;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_bus_initiator #(.WAIT_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .address      (address),
        .read         (read),
        .write        (write),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .readdata     (readdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_mis(input int sz, input logic [31:0] a);
        if (sz == 3) return 1'b1;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_be(input int sz, input logic [31:0] a);
        int o = int'(a % 4);
        if (sz == 0) return 32'(1 << o);
        if (sz == 1) return 32'(3 << o);
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input int sz, input logic [31:0] wd);
        if (sz == 0) return (wd % 256) * 32'h01010101;
        if (sz == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input int sz, input logic [31:0] a, input logic uns,
                                         input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        if (sz == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int stalls);
        logic mis;
        logic tout;
        int   exp_cyc;
        mis     = m_mis(int'(sz), addr);
        tout    = (stalls >= LIMIT);
        exp_cyc = tout ? LIMIT : stalls + 1;
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        waitrequest  = 1'($urandom % 2);
        readdata     = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (mis) begin
            check("mis_valid", 32'(rsp_valid), 32'd1);
            check("mis_error", 32'(rsp_error), 32'd1);
            check("mis_nostrobe", 32'({read, write}), 32'd0);
            check("mis_rdata", rsp_rdata, 32'd0);
        end else begin
            for (int k = 0; k < exp_cyc; k++) begin
                check("strobe", 32'({read, write}), wr ? 32'd1 : 32'd2);
                check("address", address, addr & 32'hFFFFFFFC);
                check("byteenable", 32'(byteenable), m_be(int'(sz), addr));
                if (wr) check("writedata", writedata, m_wd(int'(sz), wd));
                check("no_rsp_busy", 32'(rsp_valid), 32'd0);
                check("not_ready_busy", 32'(req_ready), 32'd0);
                waitrequest = (k < stalls);
                readdata    = $urandom;
                req_valid   = 1'($urandom % 2);
                @(negedge clk);
            end
            req_valid   = 1'b0;
            waitrequest = 1'($urandom % 2);
            check("strobe_off", 32'({read, write}), 32'd0);
            check("address_off", address, 32'd0);
            check("be_off", 32'(byteenable), 32'd0);
            check("wd_off", writedata, 32'd0);
            if (!wr && !tout) begin
                check("data_no_rsp", 32'(rsp_valid), 32'd0);
                readdata = rd;
                @(negedge clk);
                readdata = $urandom;
                check("ld_valid", 32'(rsp_valid), 32'd1);
                check("ld_error", 32'(rsp_error), 32'd0);
                check("ld_rdata", rsp_rdata, m_rd(int'(sz), addr, uns, rd));
            end else begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_error", 32'(rsp_error), 32'(tout));
                check("rsp_rdata", rsp_rdata, 32'd0);
            end
        end
        @(negedge clk);
        check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        waitrequest  = 1'b0;
        readdata     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_strobes", 32'({read, write}), 32'd0);
        check("rst_be", 32'(byteenable), 32'd0);
        check("rst_wd", writedata, 32'd0);
        reset = 1'b0;

        run_txn(1'b1, 2'b10, 1'b0, 32'hBFC00100, 32'h43211234, 32'd0, 0);
        run_txn(1'b0, 2'b00, 1'b0, 32'hBFC00103, 32'd0, 32'h80112233, 0);
        run_txn(1'b0, 2'b00, 1'b1, 32'hBFC00103, 32'd0, 32'h80112233, 0);
        run_txn(1'b1, 2'b01, 1'b0, 32'hBFC00102, 32'h0000ABCD, 32'd0, 3);
        run_txn(1'b0, 2'b10, 1'b0, 32'hBFC00101, 32'd0, 32'h12345678, 0);
        run_txn(1'b0, 2'b10, 1'b0, 32'hBFC00200, 32'd0, 32'hDEADBEEF, 8);
        run_txn(1'b0, 2'b01, 1'b0, 32'hBFC00202, 32'd0, 32'h9ABC0000, 1);
        run_txn(1'b1, 2'b00, 1'b0, 32'hBFC00301, 32'h000000A5, 32'd0, LIMIT);

        // Reset in the middle of a stalled read
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'hBFC00400;
        waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_read", 32'(read), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_strobes", 32'({read, write}), 32'd0);
        check("mid_rst_be", 32'(byteenable), 32'd0);
        check("mid_rst_address", address, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            check("post_rst_ready", 32'(req_ready), 32'd1);
        end

        for (int n = 0; n < 40; n++) begin
            sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            a  = $urandom;
            if (($urandom % 4 != 0) && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            run_txn(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, $urandom,
                    int'($urandom % 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
